// File: rtl/xfer_sched_rr.sv
// xfer_sched_rr
//   Two-requester round-robin scheduler for the byte-to-word transfer
//   datapath. A granted job reads byte pairs from the byte RAM (async read)
//   and writes each pair as one word {first, second} to the word RAM.
//
// Ports
//   clk, rset                    clock, synchronous active-high reset
//   req[1:0]                     request levels, held until matching done
//   src_addr0/1, dst_addr0/1     job start addresses (byte / word)
//   len_m1_0/1                   job length in words minus one
//   ack[1:0]                     one-hot grant pulse, descriptor sampled here
//   done[1:0]                    one-hot completion pulse
//   busy                         ack cycle through done cycle inclusive
//   mem_in_addr_rd/data_rd       byte-RAM read port
//   mem_out_we/addr_wr/data_wr   word-RAM write port
module xfer_sched_rr #(
    parameter int BYTE_AW = 5,
    parameter int WORD_AW = 4,
    parameter int BYTE_W  = 8,
    parameter int LEN_W   = 4
) (
    input  logic                  clk,
    input  logic                  rset,
    input  logic [1:0]            req,
    input  logic [BYTE_AW-1:0]    src_addr0,
    input  logic [BYTE_AW-1:0]    src_addr1,
    input  logic [WORD_AW-1:0]    dst_addr0,
    input  logic [WORD_AW-1:0]    dst_addr1,
    input  logic [LEN_W-1:0]      len_m1_0,
    input  logic [LEN_W-1:0]      len_m1_1,
    output logic [1:0]            ack,
    output logic [1:0]            done,
    output logic                  busy,
    output logic [BYTE_AW-1:0]    mem_in_addr_rd,
    input  logic [BYTE_W-1:0]     mem_in_data_rd,
    output logic                  mem_out_we,
    output logic [WORD_AW-1:0]    mem_out_addr_wr,
    output logic [2*BYTE_W-1:0]   mem_out_data_wr
);

    typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, WR, FIN} state_t;

    state_t                 state_reg;
    logic                   g_reg;           // requester owning the current job
    logic                   last_grant_reg;  // requester served most recently
    logic [BYTE_AW-1:0]     src_ptr_reg;
    logic [WORD_AW-1:0]     dst_ptr_reg;
    logic [LEN_W-1:0]       rem_reg;
    logic [BYTE_W-1:0]      hi_reg;
    logic [BYTE_AW-1:0]     rd_addr_reg;
    logic                   we_reg;
    logic [WORD_AW-1:0]     wa_reg;
    logic [2*BYTE_W-1:0]    wd_reg;
    logic [1:0]             done_reg;
    logic                   busy_reg;

    logic                   g_next;
    logic                   grant_en;
    logic [BYTE_AW-1:0]     src_sel;
    logic [WORD_AW-1:0]     dst_sel;
    logic [LEN_W-1:0]       len_sel;

    // Tie goes to the requester not served last; a lone request wins outright.
    always_comb begin
        g_next  = (req == 2'b11) ? ~last_grant_reg : (req[1] & ~req[0]);
        src_sel = g_next ? src_addr1 : src_addr0;
        dst_sel = g_next ? dst_addr1 : dst_addr0;
        len_sel = g_next ? len_m1_1  : len_m1_0;
    end

    // The grant must be visible in the very cycle the descriptor is sampled,
    // so ack is decoded from state and req rather than registered.
    assign grant_en = (state_reg == IDLE) && (|req) && !rset;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack[gi] = grant_en && (g_next == 1'(gi));
        end
    endgenerate

    assign busy            = busy_reg | grant_en;
    assign done            = done_reg;
    assign mem_in_addr_rd  = rd_addr_reg;
    // Gating with rset keeps a reset that lands on a WR cycle from committing
    // that word at the reset edge.
    assign mem_out_we      = we_reg & ~rset;
    assign mem_out_addr_wr = wa_reg;
    assign mem_out_data_wr = wd_reg;

    // Read address, write strobe and done are set one edge ahead so they are
    // valid for the whole of the state they belong to.
    always_ff @(posedge clk) begin
        if (rset) begin
            state_reg      <= IDLE;
            g_reg          <= 1'b0;
            last_grant_reg <= 1'b1;
            src_ptr_reg    <= '0;
            dst_ptr_reg    <= '0;
            rem_reg        <= '0;
            hi_reg         <= '0;
            rd_addr_reg    <= '0;
            we_reg         <= 1'b0;
            wa_reg         <= '0;
            wd_reg         <= '0;
            done_reg       <= '0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        g_reg       <= g_next;
                        src_ptr_reg <= src_sel;
                        dst_ptr_reg <= dst_sel;
                        rem_reg     <= len_sel;
                        rd_addr_reg <= src_sel;
                        busy_reg    <= 1'b1;
                        state_reg   <= RD_HI;
                    end
                end
                RD_HI: begin
                    hi_reg      <= mem_in_data_rd;
                    src_ptr_reg <= src_ptr_reg + BYTE_AW'(1);
                    rd_addr_reg <= src_ptr_reg + BYTE_AW'(1);
                    state_reg   <= RD_LO;
                end
                RD_LO: begin
                    // Low byte goes straight into the write word.
                    src_ptr_reg <= src_ptr_reg + BYTE_AW'(1);
                    rd_addr_reg <= '0;
                    we_reg      <= 1'b1;
                    wa_reg      <= dst_ptr_reg;
                    wd_reg      <= {hi_reg, mem_in_data_rd};
                    state_reg   <= WR;
                end
                WR: begin
                    we_reg <= 1'b0;
                    if (rem_reg == '0) begin
                        done_reg  <= {g_reg, ~g_reg};
                        state_reg <= FIN;
                    end else begin
                        rem_reg     <= rem_reg - LEN_W'(1);
                        dst_ptr_reg <= dst_ptr_reg + WORD_AW'(1);
                        rd_addr_reg <= src_ptr_reg;
                        state_reg   <= RD_HI;
                    end
                end
                FIN: begin
                    done_reg       <= '0;
                    last_grant_reg <= g_reg;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
